// File: rtl/alu_64.sv
// alu_64 -- 64-bit integer ALU for the execute stage of the sequential
// RISC-V datapath.
//
// Ports:
//   clk          clock for the sticky overflow bit (and the optional output register)
//   rst_n        asynchronous active-low reset
//   A, B         64-bit operands
//   ALU_control  4-bit operation select (codes 1010..1111 yield out=0, ovf=0)
//   out          result
//   zero         1 when out == 0
//   ovf          signed overflow of ADD/SUB, 0 for every other operation
//   ovf_sticky   set on any clk edge that sees ovf=1; cleared only by reset
//
// Configuration:
//   ALU_OUT_REG_EN  when defined, out/zero/ovf are registered (1-cycle latency,
//                   reset to out=0, zero=1, ovf=0) and ovf_sticky samples the
//                   registered ovf. Default (undefined): out/zero/ovf are
//                   combinational.

module alu_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [3:0]  ALU_control,
  output logic [63:0] out,
  output logic        zero,
  output logic        ovf,
  output logic        ovf_sticky
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  logic [63:0] res_c;
  logic        ovf_c;
  logic        zero_c;
  logic [5:0]  shamt;

  // Only the low six bits of B select the shift distance.
  assign shamt = B[5:0];

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (ALU_control)
      OP_ADD: begin
        res_c = A + B;
        ovf_c = (A[63] == B[63]) && (res_c[63] != A[63]);
      end
      OP_SUB: begin
        res_c = A - B;
        ovf_c = (A[63] != B[63]) && (res_c[63] != A[63]);
      end
      OP_AND:  res_c = A & B;
      OP_OR:   res_c = A | B;
      OP_XOR:  res_c = A ^ B;
      OP_SLL:  res_c = A << shamt;
      OP_SRL:  res_c = A >> shamt;
      OP_SRA:  res_c = $unsigned($signed(A) >>> shamt);
      OP_SLT:  res_c = {63'b0, $signed(A) < $signed(B)};
      OP_SLTU: res_c = {63'b0, A < B};
      default: res_c = '0;
    endcase
  end

  assign zero_c = ~|res_c;

`ifdef ALU_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      zero <= 1'b1;
      ovf  <= 1'b0;
    end else begin
      out  <= res_c;
      zero <= zero_c;
      ovf  <= ovf_c;
    end
  end
`else
  assign out  = res_c;
  assign zero = zero_c;
  assign ovf  = ovf_c;
`endif

  // Sticky bit follows the visible ovf, so in the registered build it lags
  // the operation that overflowed by one extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ovf_sticky <= 1'b0;
    else if (ovf) ovf_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_alu_64.sv
// tb_alu_64 -- directed self-checking bench for alu_64 (default combinational build).
//
// Ports of the DUT are all driven/observed here; inputs change just after a
// falling clock edge and outputs are sampled 1 time unit later, well away from
// the rising edge that updates ovf_sticky.

module tb_alu_64;

  logic        clk;
  logic        rst_n;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  ALU_control;
  logic [63:0] out;
  logic        zero;
  logic        ovf;
  logic        ovf_sticky;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  alu_64 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .out         (out),
    .zero        (zero),
    .ovf         (ovf),
    .ovf_sticky  (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
  endtask

  // Apply one vector after a falling edge, then check out/zero/ovf.
  task automatic apply(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_out,
                       input logic exp_ovf);
    @(negedge clk);
    A = a;
    B = b;
    ALU_control = op;
    #1;
    check({tag, ".out"},  out,  exp_out);
    check({tag, ".zero"}, {63'b0, zero}, {63'b0, exp_out == 64'd0});
    check({tag, ".ovf"},  {63'b0, ovf},  {63'b0, exp_ovf});
  endtask

  initial begin
    rst_n = 1'b0;
    A = '0;
    B = '0;
    ALU_control = 4'b0000;
    #2;
    check("reset.sticky", {63'b0, ovf_sticky}, 64'd0);
    check("reset.out",    out, 64'd0);
    check("reset.zero",   {63'b0, zero}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    apply("add10",  4'b0000, 64'h10, 64'h10, 64'h20, 1'b0);
    apply("sub10",  4'b0001, 64'h10, 64'h10, 64'h0,  1'b0);
    apply("and10",  4'b0010, 64'h10, 64'h10, 64'h10, 1'b0);
    apply("or10",   4'b0011, 64'h10, 64'h10, 64'h10, 1'b0);
    apply("xor",    4'b0100, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0);
    apply("addm1",  4'b0000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'h0, 1'b0);
    apply("subm1",  4'b0001, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    apply("addneg", 4'b0000, 64'hFFFFFFFFFFFFFFF6, 64'd5, 64'hFFFFFFFFFFFFFFFB, 1'b0);
    apply("subneg", 4'b0001, 64'hFFFFFFFFFFFFFFF6, 64'd5, 64'hFFFFFFFFFFFFFFF1, 1'b0);
    apply("slt",    4'b1000, 64'hFFFFFFFFFFFFFFF6, 64'd5, 64'd1, 1'b0);
    apply("sltu",   4'b1001, 64'hFFFFFFFFFFFFFFF6, 64'd5, 64'd0, 1'b0);
    apply("sltu2",  4'b1001, 64'd5, 64'hFFFFFFFFFFFFFFF6, 64'd1, 1'b0);
    apply("sra4",   4'b0111, 64'h8000000000000000, 64'd4, 64'hF800000000000000, 1'b0);
    apply("srl4",   4'b0110, 64'h8000000000000000, 64'd4, 64'h0800000000000000, 1'b0);
    apply("sll63",  4'b0101, 64'd1, 64'd63, 64'h8000000000000000, 1'b0);
    apply("sll0",   4'b0101, 64'h123456789ABCDEF0, 64'd0, 64'h123456789ABCDEF0, 1'b0);
    apply("sllhiB", 4'b0101, 64'd1, 64'hFFFFFFFFFFFFFFC4, 64'h10, 1'b0);
    apply("sra63",  4'b0111, 64'h8000000000000000, 64'd63, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    apply("srl63",  4'b0110, 64'h8000000000000000, 64'd63, 64'd1, 1'b0);
    apply("undefA", 4'b1010, 64'h1234, 64'h5678, 64'd0, 1'b0);
    apply("undefF", 4'b1111, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b0);

    // No overflow seen yet, so the sticky bit must still be clear.
    check("sticky.idle", {63'b0, ovf_sticky}, 64'd0);

    apply("subovf", 4'b0001, 64'h8000000000000000, 64'd1, 64'h7FFFFFFFFFFFFFFF, 1'b1);
    @(posedge clk);
    #1;
    check("sticky.sub", {63'b0, ovf_sticky}, 64'd1);

    // Clear via reset, then set again with the ADD overflow case.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check("sticky.clr1", {63'b0, ovf_sticky}, 64'd0);
    apply("addovf", 4'b0000, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, 1'b1);
    check("sticky.pre", {63'b0, ovf_sticky}, 64'd0);
    @(posedge clk);
    #1;
    check("sticky.add", {63'b0, ovf_sticky}, 64'd1);

    // Holds through non-overflow operations.
    apply("undef2", 4'b1111, 64'hAAAA, 64'h5555, 64'd0, 1'b0);
    @(posedge clk);
    #1;
    check("sticky.hold", {63'b0, ovf_sticky}, 64'd1);

    // Asynchronous clear between edges, while an overflowing op is applied.
    apply("addovf2", 4'b0000, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, 1'b1);
    rst_n = 1'b0;
    #1;
    check("sticky.async", {63'b0, ovf_sticky}, 64'd0);
    @(posedge clk);
    #1;
    check("sticky.inrst", {63'b0, ovf_sticky}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ALU_control = 4'b0010;
    @(posedge clk);
    #1;
    check("sticky.rel", {63'b0, ovf_sticky}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
